// File: rtl/uart_tx_encoder_if.sv
// Host-side word interface of the UART transmit encoder.
//
// Handshake: a word {tx_address, tx_data} is transferred on a rising clk
// edge where tx_valid && tx_ready are both high. tx_ready does not depend
// on tx_valid. A master may hold or change the word while tx_ready is low.
// Once the word has been accepted, it may change freely.
//
// Signals:
//   tx_valid    master -> slave  a word is offered
//   tx_address  master -> slave  address nibble, becomes byte[7:4]
//   tx_data     master -> slave  data nibble, becomes byte[3:0]
//   tx_ready    slave  -> master slave can accept a word (buffer not full)
interface uart_tx_encoder_if;
  logic       tx_valid;
  logic [3:0] tx_address;
  logic [3:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_address,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_address,
    input  tx_data,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_encoder.sv
// UART transmit encoder.
//
// Each {address, data} nibble pair is packed into one byte (address in
// [7:4], data in [3:0]) and stored in a small FIFO. The bytes are sent LSB
// first as 8N1/8E1/8O1 frames, with 1 or 2 stop bits. Bit timing comes from
// the 16x-baud tick: every bit lasts exactly 16 ticks.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   tick_16x     one-clk enable at 16x the baud rate
//   host_if      word handshake (slave side): tx_valid/tx_address/tx_data in,
//                tx_ready out
//   Tx           serial line, idles high
//   busy         high from start-bit load until the last stop bit ends
//   frame_sent   one-clk pulse after the final stop bit completes
//   dbg_state_o  FSM state: 0=IDLE 1=START 2=DATA 3=PARITY 4=STOP
module uart_tx_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_16x,
  uart_tx_encoder_if.slave   host_if,
  output logic               Tx,
  output logic               busy,
  output logic               frame_sent,
  output logic [2:0]         dbg_state_o
);

  localparam int   AW      = $clog2(FIFO_DEPTH);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shreg_q;
  logic        stop_idx_q;
  logic        tx_q;
  logic        busy_q;
  logic        frame_sent_q;

  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        bit_end;
  logic        stop_last;
  logic        parity_bit;
  logic [7:0]  head_byte;

  // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
  // differing only in the wrap bit mean full.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign head_byte = mem_q[rd_ptr_q[AW-1:0]];

  // A bit ends on the tick that takes the counter from 15 back to 0.
  assign bit_end   = tick_16x && (cnt_q == 4'd15);
  assign stop_last = (STOP_BITS == 1) || stop_idx_q;

  // Pop either to start a frame from idle, or on the final stop tick so the
  // next frame follows with no idle gap.
  assign pop = !empty && tick_16x &&
               ((state_q == S_IDLE) ||
                ((state_q == S_STOP) && (cnt_q == 4'd15) && stop_last));

  // Push is refused while full even if a pop happens in the same cycle.
  assign push             = host_if.tx_valid && !full;
  assign host_if.tx_ready = !full;

  assign parity_bit = (^shreg_q) ^ PAR_ODD;

  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {host_if.tx_address, host_if.tx_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 3'd0;
      shreg_q      <= 8'd0;
      stop_idx_q   <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_sent_q <= 1'b0;
    end else begin
      frame_sent_q <= 1'b0;
      // Counter wraps naturally to 0 at each bit end.
      if (tick_16x && (state_q != S_IDLE)) begin
        cnt_q <= cnt_q + 4'd1;
      end
      case (state_q)
        S_IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shreg_q <= head_byte;
            tx_q    <= 1'b0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            tx_q      <= shreg_q[0];
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                tx_q    <= parity_bit;
                state_q <= S_PARITY;
              end else begin
                tx_q       <= 1'b1;
                stop_idx_q <= 1'b0;
                state_q    <= S_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[bit_idx_q + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            tx_q       <= 1'b1;
            stop_idx_q <= 1'b0;
            state_q    <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (!stop_last) begin
              stop_idx_q <= 1'b1;
            end else begin
              frame_sent_q <= 1'b1;
              if (pop) begin
                shreg_q <= head_byte;
                tx_q    <= 1'b0;
                state_q <= S_START;
              end else begin
                busy_q  <= 1'b0;
                state_q <= S_IDLE;
              end
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Tx          = tx_q;
  assign busy        = busy_q;
  assign frame_sent  = frame_sent_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_encoder.sv
module tb_uart_tx_encoder;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       tick = 1'b0;
  logic       tx_valid = 1'b0;
  logic [3:0] tx_address = 4'h0;
  logic [3:0] tx_data = 4'h0;
  int         tick_mode = 1;   // 0 off, 1 every clk, 2 every 3rd clk, 3 random

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- three configurations, each with its own model ----------------
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int PEN   = (g == 2) ? 0 : 1;
    localparam int PODD  = (g == 1) ? 1 : 0;
    localparam int NSTOP = (g == 1) ? 2 : 1;
    localparam int FLEN  = 1 + 8 + PEN + NSTOP;

    uart_tx_encoder_if bus ();
    logic       tx_w, busy_w, fs_w, rdy_w;
    logic [2:0] st_w;

    assign bus.tx_valid   = tx_valid;
    assign bus.tx_address = tx_address;
    assign bus.tx_data    = tx_data;
    assign rdy_w          = bus.tx_ready;

    uart_tx_encoder #(
      .FIFO_DEPTH(DEPTH),
      .PARITY_EN (PEN),
      .PARITY_ODD(PODD),
      .STOP_BITS (NSTOP)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .tick_16x   (tick),
      .host_if    (bus),
      .Tx         (tx_w),
      .busy       (busy_w),
      .frame_sent (fs_w),
      .dbg_state_o(st_w)
    );

    // Reference: a queue of buffered bytes, and the current frame as a bit
    // vector indexed by (ticks elapsed / 16).
    logic [7:0]  exp_q[$];
    int          q_size = 0;
    bit          active = 1'b0;
    int          t = 0;
    logic [11:0] bits = '1;
    logic        m_tx = 1'b1, m_busy = 1'b0, m_fs = 1'b0, m_ready = 1'b1;

    always @(posedge clk) begin : p_model
      bit         do_push;
      logic [7:0] b;
      if (rst) begin
        exp_q.delete();
        active = 1'b0;
        t      = 0;
        m_fs   = 1'b0;
      end else begin
        m_fs    = 1'b0;
        do_push = tx_valid && (exp_q.size() < DEPTH);
        if (tick) begin
          if (active) begin
            t++;
            if (t == FLEN * 16) begin
              m_fs   = 1'b1;
              active = 1'b0;
            end
          end
          if (!active && exp_q.size() > 0) begin
            b       = exp_q.pop_front();
            bits    = '1;
            bits[0] = 1'b0;
            bits[8:1] = b;
            if (PEN != 0) bits[9] = (^b) ^ (PODD != 0);
            active  = 1'b1;
            t       = 0;
          end
        end
        if (do_push) exp_q.push_back({tx_address, tx_data});
      end
      q_size  = exp_q.size();
      m_busy  = active;
      m_tx    = active ? bits[t / 16] : 1'b1;
      m_ready = (exp_q.size() < DEPTH);
    end
  end

  // ---------------- continuous scoreboard, sampled on the falling edge ----------------
  always @(negedge clk) begin
    check_eq("c0_tx",   g_cfg[0].tx_w,   g_cfg[0].m_tx);
    check_eq("c0_busy", g_cfg[0].busy_w, g_cfg[0].m_busy);
    check_eq("c0_fs",   g_cfg[0].fs_w,   g_cfg[0].m_fs);
    check_eq("c0_rdy",  g_cfg[0].rdy_w,  g_cfg[0].m_ready);
    check_eq("c1_tx",   g_cfg[1].tx_w,   g_cfg[1].m_tx);
    check_eq("c1_busy", g_cfg[1].busy_w, g_cfg[1].m_busy);
    check_eq("c1_fs",   g_cfg[1].fs_w,   g_cfg[1].m_fs);
    check_eq("c1_rdy",  g_cfg[1].rdy_w,  g_cfg[1].m_ready);
    check_eq("c2_tx",   g_cfg[2].tx_w,   g_cfg[2].m_tx);
    check_eq("c2_busy", g_cfg[2].busy_w, g_cfg[2].m_busy);
    check_eq("c2_fs",   g_cfg[2].fs_w,   g_cfg[2].m_fs);
    check_eq("c2_rdy",  g_cfg[2].rdy_w,  g_cfg[2].m_ready);
  end

  // ---------------- tick generator ----------------
  int fs_cnt0 = 0;
  initial begin
    int cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      case (tick_mode)
        0:       tick = 1'b0;
        1:       tick = 1'b1;
        2:       tick = ((cyc % 3) == 0);
        default: tick = ($urandom_range(0, 3) == 0);
      endcase
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (g_cfg[0].fs_w === 1'b1) fs_cnt0++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks (called on a falling edge) ----------------
  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_word(input logic [3:0] a, input logic [3:0] d, input int max_wait, output bit ok);
    int n = 0;
    tx_valid   = 1'b1;
    tx_address = a;
    tx_data    = d;
    while (g_cfg[0].rdy_w !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    ok = (n < max_wait);
    @(negedge clk);
    tx_valid   = 1'b0;
    tx_address = 4'($urandom);
    tx_data    = 4'($urandom);
  endtask

  task automatic measure_busy(input int max_wait, output int len);
    int n = 0;
    len = 0;
    while (g_cfg[0].busy_w !== 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
    end
    while (g_cfg[0].busy_w === 1'b1 && n < max_wait) begin
      @(negedge clk);
      n++;
      len++;
    end
  endtask

  // ---------------- directed and random phases ----------------
  initial begin
    bit ok;
    int len, snap, n;

    repeat (3) @(negedge clk);
    check_eq("rst_tx",    g_cfg[0].tx_w,   1);
    check_eq("rst_busy",  g_cfg[0].busy_w, 0);
    check_eq("rst_rdy",   g_cfg[0].rdy_w,  1);
    check_eq("rst_fs",    g_cfg[0].fs_w,   0);
    check_eq("rst_state", g_cfg[0].st_w,   0);
    rst = 1'b0;

    // Single 0xA5 frame, tick every clk: 11 bits x 16 clk.
    tick_mode = 1;
    snap = fs_cnt0;
    push_word(4'hA, 4'h5, 20, ok);
    check_eq("p1_accept", ok, 1);
    measure_busy(400, len);
    check_eq("p1_busy_len", len, 176);
    repeat (10) @(negedge clk);
    check_eq("p1_frames", fs_cnt0 - snap, 1);

    // Sparse tick, one per 3 clk: each bit lasts 48 clk.
    do_reset();
    tick_mode = 2;
    snap = fs_cnt0;
    push_word(4'h3, 4'hC, 20, ok);
    check_eq("p2_accept", ok, 1);
    measure_busy(1200, len);
    check_eq("p2_busy_len", len, 528);
    repeat (10) @(negedge clk);
    check_eq("p2_frames", fs_cnt0 - snap, 1);

    // Fill the FIFO with ticks off, hold a fifth word, then drain.
    do_reset();
    tick_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      push_word(4'($urandom), 4'($urandom), 20, ok);
      check_eq("p3_accept", ok, 1);
    end
    check_eq("p3_full_rdy", g_cfg[0].rdy_w, 0);
    tx_valid   = 1'b1;
    tx_address = 4'($urandom);
    tx_data    = 4'($urandom);
    repeat (10) @(negedge clk);
    check_eq("p3_held_rdy", g_cfg[0].rdy_w, 0);
    snap = fs_cnt0;
    tick_mode = 1;
    push_word(tx_address, tx_data, 400, ok);
    check_eq("p3_fifth_accept", ok, 1);
    repeat (5 * 176 + 40) @(negedge clk);
    check_eq("p3_frames", fs_cnt0 - snap, 5);

    // Reset during data bit 3 with two words queued.
    do_reset();
    tick_mode = 1;
    for (int i = 0; i < 3; i++) push_word(4'($urandom), 4'($urandom), 20, ok);
    n = 0;
    while (!(g_cfg[0].active && (g_cfg[0].t / 16) == 4) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("p4_reach_bit3", (n < 400), 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("p4_tx",   g_cfg[0].tx_w,   1);
    check_eq("p4_busy", g_cfg[0].busy_w, 0);
    check_eq("p4_rdy",  g_cfg[0].rdy_w,  1);
    rst  = 1'b0;
    snap = fs_cnt0;
    repeat (400) @(negedge clk);
    check_eq("p4_frames", fs_cnt0 - snap, 0);

    // Push exactly on the final stop tick that pops the last buffered word.
    do_reset();
    tick_mode = 1;
    snap = fs_cnt0;
    push_word(4'h1, 4'h2, 20, ok);
    push_word(4'h3, 4'h4, 20, ok);
    n = 0;
    while (!(g_cfg[0].active && g_cfg[0].t == 175 && g_cfg[0].q_size == 1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("p5_reach_stop", (n < 400), 1);
    tx_valid   = 1'b1;
    tx_address = 4'h5;
    tx_data    = 4'h6;
    @(negedge clk);
    tx_valid   = 1'b0;
    repeat (2 * 176 + 40) @(negedge clk);
    check_eq("p5_frames", fs_cnt0 - snap, 3);

    // Random traffic with a random tick.
    do_reset();
    tick_mode = 3;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      tx_valid   = ($urandom_range(0, 2) == 0);
      tx_address = 4'($urandom);
      tx_data    = 4'($urandom);
    end
    tx_valid  = 1'b0;
    tick_mode = 1;
    repeat (1000) @(negedge clk);
    check_eq("p6_drained_busy", g_cfg[1].busy_w, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
